uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, error-bit indices, parameter defaults.
// Optional feature macro: UART_RX_SYNC_EN (two-flop Rx synchronizer).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DONE,
      BRK_WAIT
   } uart_state_e;

   localparam int ERR_BREAK  = 0;
   localparam int ERR_PARITY = 1;
   localparam int ERR_FRAME  = 2;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_PARITY_BIT = 1;
   localparam int DEF_STOP_BITS  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
// Instantiated by uart_receiver only when UART_RX_SYNC_EN is defined.
module uart_rx_sync (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Rx,
   output logic Rx_Sync
);

   logic meta;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         meta    <= 1'b1;
         Rx_Sync <= 1'b1;
      end else begin
         meta    <= Rx;
         Rx_Sync <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver clocked at the baud rate: start, MSB-first data, optional even parity, stop bits.
// Define UART_RX_SYNC_EN to insert a two-flop synchronizer on Rx (adds 2 cycles of latency).
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int PARITY_BIT = DEF_PARITY_BIT,
   parameter int STOP_BITS  = DEF_STOP_BITS
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Rx,
   input  logic                 Fifo_Full,
   input  logic                 Err_Clr,
   output logic [DATA_BITS-1:0] Data_Out,
   output logic                 Data_Valid,
   output logic [2:0]           Rx_Error,
   output logic                 RTS,
   output logic                 Overrun
);

   localparam int MAX_CNT = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   uart_rx_sync u_rx_sync (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Rx      (Rx),
      .Rx_Sync (rx_s)
   );
`else
   assign rx_s = Rx;
`endif

   uart_state_e          state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 cnt_done;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc, par_err, frm_err, all_zero;
   logic [2:0]           err_word;

   assign cnt_done = (cnt == '0);

   always_ff @(posedge Clk) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!rx_s) state_nxt = DATA;
         DATA:     if (cnt_done) state_nxt = (PARITY_BIT != 0) ? PARITY : STOP;
         PARITY:   state_nxt = STOP;
         STOP:     if (cnt_done) state_nxt = DONE;
         DONE:     state_nxt = all_zero ? BRK_WAIT : IDLE;
         BRK_WAIT: if (rx_s) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // A break reports only the break bit; parity/frame flags are masked.
   always_comb begin
      err_word = '0;
      if (all_zero) begin
         err_word[ERR_BREAK] = 1'b1;
      end else begin
         err_word[ERR_PARITY] = par_err;
         err_word[ERR_FRAME]  = frm_err;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         cnt        <= '0;
         shreg      <= '0;
         par_acc    <= 1'b0;
         par_err    <= 1'b0;
         frm_err    <= 1'b0;
         all_zero   <= 1'b0;
         Data_Out   <= '0;
         Data_Valid <= 1'b0;
         Rx_Error   <= '0;
         RTS        <= 1'b0;
         Overrun    <= 1'b0;
      end else begin
         RTS        <= ~Fifo_Full;
         Data_Valid <= 1'b0;

         // Counter reloads whenever the FSM enters a new state.
         if (state_nxt != state) begin
            case (state_nxt)
               DATA:    cnt <= DATA_LAST;
               STOP:    cnt <= STOP_LAST;
               default: cnt <= '0;
            endcase
         end else if (!cnt_done) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (Err_Clr) Overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  par_acc  <= 1'b0;
                  par_err  <= 1'b0;
                  frm_err  <= 1'b0;
                  all_zero <= 1'b1;
               end
            end
            DATA: begin
               shreg    <= DATA_BITS'({shreg, rx_s});
               par_acc  <= par_acc ^ rx_s;
               all_zero <= all_zero & ~rx_s;
            end
            PARITY: begin
               par_err  <= (rx_s != par_acc);
               all_zero <= all_zero & ~rx_s;
            end
            STOP: begin
               if (!rx_s) frm_err <= 1'b1;
               all_zero <= all_zero & ~rx_s;
            end
            DONE: begin
               // Overrun set overrides a coincident Err_Clr.
               if (!Fifo_Full) begin
                  Data_Valid <= 1'b1;
                  Data_Out   <= shreg;
                  Rx_Error   <= err_word;
               end else begin
                  Overrun <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frame stimulus for uart_receiver, checked against a frame-level model.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
   localparam int LAT = 14;
`else
   localparam int LAT = 12;
`endif

   logic       Clk = 1'b0;
   logic       Rst_n, Rx, Fifo_Full, Err_Clr;
   logic [7:0] Data_Out;
   logic       Data_Valid;
   logic [2:0] Rx_Error;
   logic       RTS, Overrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int         qc[$];
   logic [7:0] qd[$];
   logic [2:0] qe[$];

   uart_receiver #(.DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Rx         (Rx),
      .Fifo_Full  (Fifo_Full),
      .Err_Clr    (Err_Clr),
      .Data_Out   (Data_Out),
      .Data_Valid (Data_Valid),
      .Rx_Error   (Rx_Error),
      .RTS        (RTS),
      .Overrun    (Overrun)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (Data_Valid === 1'b1) begin
         qc.push_back(cyc);
         qd.push_back(Data_Out);
         qe.push_back(Rx_Error);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      qc.delete();
      qd.delete();
      qe.delete();
   endtask

   // Frame-level rules: break if every sample is 0, else even-parity and stop-bit checks.
   function automatic logic [2:0] model_err(input logic [7:0] d, input logic p, input logic [1:0] s);
      logic [2:0] e;
      e = 3'b000;
      if (d == 8'h00 && p == 1'b0 && s == 2'b00) return 3'b001;
      e[1] = (p != ^d);
      e[2] = (s != 2'b11);
      return e;
   endfunction

   task automatic send(input logic [7:0] d, input logic p, input logic [1:0] s, output int start);
      logic [11:0] bits;
      bits = {1'b0, d, p, s};
      @(negedge Clk);
      Rx    = bits[11];
      start = cyc + 1;
      for (int i = 10; i >= 0; i--) begin
         @(negedge Clk);
         Rx = bits[i];
      end
      @(negedge Clk);
      Rx = 1'b1;
   endtask

   task automatic expect_word(input string tag, input int start, input logic [7:0] d,
                              input logic [2:0] e);
      repeat (LAT + 4) @(negedge Clk);
      #1;
      chk({tag, ".count"}, 32'(qc.size()), 32'd1);
      if (qc.size() >= 1) begin
         chk({tag, ".cycle"}, 32'(qc[0]), 32'(start + LAT));
         chk({tag, ".data"},  32'(qd[0]), 32'(d));
         chk({tag, ".err"},   32'(qe[0]), 32'(e));
      end
      chk({tag, ".hold"}, 32'(Data_Out), 32'(d));
      clear_q();
   endtask

   initial begin
      int         st, target;
      logic [7:0] d;
      logic       p;
      logic [1:0] s;

      Rst_n = 1'b0; Rx = 1'b1; Fifo_Full = 1'b0; Err_Clr = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst.data",    32'(Data_Out),   32'd0);
      chk("rst.valid",   32'(Data_Valid), 32'd0);
      chk("rst.err",     32'(Rx_Error),   32'd0);
      chk("rst.overrun", 32'(Overrun),    32'd0);
      chk("rst.rts",     32'(RTS),        32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("rts.ready", 32'(RTS), 32'd1);
      repeat (2) @(negedge Clk);
      clear_q();

      send(8'hA5, 1'b0, 2'b11, st); expect_word("a5", st, 8'hA5, 3'b000);
      send(8'hAA, 1'b1, 2'b11, st); expect_word("aa_par", st, 8'hAA, 3'b010);
      send(8'hAA, 1'b0, 2'b00, st); expect_word("aa_frm", st, 8'hAA, 3'b100);
      send(8'h55, 1'b0, 2'b11, st); expect_word("55", st, 8'h55, 3'b000);

      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         p = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
         s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         if (i == 5) begin d = 8'h00; p = 1'b0; s = 2'b00; end
         send(d, p, s, st);
         expect_word($sformatf("rnd%0d", i), st, d, model_err(d, p, s));
      end

      // Long break: one strobe, then silence until the line returns high.
      @(negedge Clk);
      Rx = 1'b0;
      st = cyc + 1;
      repeat (31) @(negedge Clk);
      #1;
      chk("brk.count", 32'(qc.size()), 32'd1);
      if (qc.size() >= 1) begin
         chk("brk.cycle", 32'(qc[0]), 32'(st + LAT));
         chk("brk.err",   32'(qe[0]), 32'(3'b001));
         chk("brk.data",  32'(qd[0]), 32'd0);
      end
      @(negedge Clk);
      Rx = 1'b1;
      repeat (LAT + 4) @(negedge Clk);
      chk("brk.quiet", 32'(qc.size()), 32'd1);
      clear_q();
      send(8'h5A, 1'b0, 2'b11, st); expect_word("post_brk", st, 8'h5A, 3'b000);

      // Full FIFO: word dropped, Overrun sticky, RTS low.
      @(negedge Clk);
      Fifo_Full = 1'b1;
      @(negedge Clk);
      chk("full.rts", 32'(RTS), 32'd0);
      send(8'h3C, 1'b0, 2'b11, st);
      repeat (LAT + 4) @(negedge Clk);
      chk("full.count",   32'(qc.size()), 32'd0);
      chk("full.overrun", 32'(Overrun),   32'd1);
      chk("full.rts2",    32'(RTS),       32'd0);
      Fifo_Full = 1'b0;
      Err_Clr   = 1'b1;
      @(negedge Clk);
      Err_Clr = 1'b0;
      chk("clr.overrun", 32'(Overrun), 32'd0);

      // Err_Clr coinciding with the drop: set must win.
      Fifo_Full = 1'b1;
      send(8'h0F, 1'b0, 2'b11, st);
      target = st + LAT - 1;
      for (int g = 0; g < 40 && cyc < target; g++) @(negedge Clk);
      chk("coin.align",  32'(cyc),     32'(target));
      chk("coin.before", 32'(Overrun), 32'd0);
      Err_Clr = 1'b1;
      @(negedge Clk);
      chk("coin.setwins", 32'(Overrun), 32'd1);
      Err_Clr = 1'b0;
      @(negedge Clk);
      chk("coin.sticky", 32'(Overrun), 32'd1);
      chk("coin.count",  32'(qc.size()), 32'd0);
      Fifo_Full = 1'b0;
      repeat (LAT) @(negedge Clk);
      clear_q();

      // Reset partway through a frame, then a clean frame.
      @(negedge Clk);
      Rx = 1'b0;
      d = 8'hB7;
      for (int i = 7; i >= 3; i--) begin
         @(negedge Clk);
         Rx = d[i];
      end
      @(negedge Clk);
      Rst_n = 1'b0;
      Rx    = 1'b1;
      repeat (2) @(negedge Clk);
      chk("midrst.overrun", 32'(Overrun), 32'd0);
      chk("midrst.data",    32'(Data_Out), 32'd0);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      send(8'hC3, 1'b0, 2'b11, st); expect_word("c3", st, 8'hC3, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
